axis_addr_arb: RTL and testbench
================================

Name: axis_addr_arb

Overview:
- Round-robin arbiter that shares one AXI write-address channel between NB_PORTS address generators (axis_addr instances).
- Each granted address beat is forwarded through a registered output stage. Its AXI ID is tagged with the source port index.
- Each grant also pushes a (port, alen) record into an order FIFO. The write-data mux pops this FIFO to steer data beats in the same order.

Parameters:
- NB_PORTS, 4, number of requesting address generators (2..16).
- PORT_WIDTH, 2, ceil(log2(NB_PORTS)); width of the port index.
- AXI_ID_WIDTH, 8, AXI ID width; must exceed PORT_WIDTH.
- AXI_LEN_WIDTH, 8, AXI burst length field width.
- AXI_ADDR_WIDTH, 32, AXI address width.
- ORDER_DEPTH, 16, order FIFO entries; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_aid  in  NB_PORTS*AXI_ID_WIDTH  per-port ID; port i occupies slice [i*AXI_ID_WIDTH +: AXI_ID_WIDTH]
- s_aaddr  in  NB_PORTS*AXI_ADDR_WIDTH  per-port address
- s_alen  in  NB_PORTS*AXI_LEN_WIDTH  per-port burst length minus one
- s_avalid  in  NB_PORTS  per-port request
- s_aready  out  NB_PORTS  per-port accept; one-hot or zero
- m_aid  out  AXI_ID_WIDTH  {port index, s_aid[AXI_ID_WIDTH-PORT_WIDTH-1:0]}
- m_aaddr  out  AXI_ADDR_WIDTH  forwarded address
- m_alen  out  AXI_LEN_WIDTH  forwarded length
- m_avalid  out  1  output beat valid
- m_aready  in  1  AXI slave accept
- wsel_port  out  PORT_WIDTH  head of order FIFO: port index
- wsel_len  out  AXI_LEN_WIDTH  head of order FIFO: burst length minus one
- wsel_valid  out  1  order FIFO non-empty
- wsel_ready  in  1  pop order FIFO

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low. All state clears on rst_n low, regardless of clk.
- Reset values:
  - m_avalid=0; m_aid, m_aaddr, m_alen=0.
  - s_aready=0 (combinational, forced 0 while rst_n low).
  - wsel_valid=0; FIFO pointers and count=0.
  - last_grant=NB_PORTS-1, so port 0 has first priority.
- Output stage states:
  - EMPTY: m_avalid=0.
  - FULL: m_avalid=1; register contents stay stable until m_aready=1.
- can_load = (EMPTY | (FULL & m_aready)) & ~fifo_full.
- Grant (combinational):
  - When can_load and any s_avalid is set, select the first set s_avalid searching from last_grant+1 upward, wrapping modulo NB_PORTS.
  - Assert s_aready for that port only. No other s_aready bit is asserted in that cycle.
- On a grant clock edge:
  - Load the output register from the granted slice, with m_aid tagged.
  - State goes to (or stays) FULL.
  - last_grant <= granted index.
  - Push {index, alen} into the order FIFO.
- On FULL & m_aready with no grant: state goes to EMPTY.
- Latency and throughput:
  - Latency from s handshake to m_avalid is 1 cycle.
  - Sustained throughput is one beat per cycle while m_aready=1.
- Fairness: a port holding s_avalid is granted within NB_PORTS grants.
- Requesters follow AXI rules: payload stable while s_avalid is high. The arbiter never drops or duplicates a beat.
- Order FIFO:
  - Registered pointers with a count of width log2(ORDER_DEPTH)+1.
  - wsel_port and wsel_len show the head entry. The FIFO is first-word-fall-through.
  - Pop occurs on wsel_valid & wsel_ready. wsel_ready while empty is ignored.
  - Simultaneous push and pop: count is unchanged, and both pointers advance.
  - fifo_full is evaluated on registered count only. A pop in the same cycle does not unblock a grant.
  - Pointers wrap modulo ORDER_DEPTH.
- Reset mid-operation:
  - Any beat in the output register is discarded. The FIFO is flushed.
  - Priority restarts at port 0.

Test Plan:
- Single-port flow: port 2 presents aid=0x05, aaddr=0x1000_0000, alen=0xFF, with m_aready=1. Required response: s_aready=4'b0100 for 1 cycle. Next cycle, m_avalid=1, m_aid=0x85, m_aaddr=0x1000_0000, m_alen=0xFF. wsel_valid=1, wsel_port=2, wsel_len=0xFF.
- Round-robin: all 4 ports request continuously after reset, m_aready=1. Required grant order 0,1,2,3,0,1. One beat per cycle. FIFO heads show ports 0,1,2,3 in order.
- Backpressure: m_aready=0 for 5 cycles with one beat held. Required: m_aaddr, m_aid and m_alen stay stable; s_aready=0 for the whole hold. After m_aready=1, the next grant proceeds on the same edge.
- FIFO full: wsel_ready=0, ORDER_DEPTH=16, with continuous requests. Required: exactly 16 grants, then s_aready=0. A wsel_ready pulse gives exactly one further grant, on the cycle after the pop.
- Simultaneous push/pop: FIFO holding 3 entries, with a grant and a pop on the same edge. Required: count stays 3 and the head advances to the next entry.
- Async reset: rst_n low mid-burst, between clock edges. Required: m_avalid and wsel_valid drop immediately, without waiting for a clock edge. After release, port 0 is granted first.

Source files
------------

// File: rtl/axis_addr_arb.sv
// Round-robin arbiter sharing one AXI write-address channel between NB_PORTS requesters.
// Granted beats go through a registered output stage; an order FIFO records (port, alen) for the W mux.
module axis_addr_arb #(
    parameter int NB_PORTS       = 4,
    parameter int PORT_WIDTH     = 2,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ORDER_DEPTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NB_PORTS*AXI_ID_WIDTH-1:0]     s_aid,
    input  logic [NB_PORTS*AXI_ADDR_WIDTH-1:0]   s_aaddr,
    input  logic [NB_PORTS*AXI_LEN_WIDTH-1:0]    s_alen,
    input  logic [NB_PORTS-1:0]                  s_avalid,
    output logic [NB_PORTS-1:0]                  s_aready,
    output logic [AXI_ID_WIDTH-1:0]              m_aid,
    output logic [AXI_ADDR_WIDTH-1:0]            m_aaddr,
    output logic [AXI_LEN_WIDTH-1:0]             m_alen,
    output logic                                 m_avalid,
    input  logic                                 m_aready,
    output logic [PORT_WIDTH-1:0]                wsel_port,
    output logic [AXI_LEN_WIDTH-1:0]             wsel_len,
    output logic                                 wsel_valid,
    input  logic                                 wsel_ready
);

    localparam int PTR_W    = $clog2(ORDER_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int LOW_ID_W = AXI_ID_WIDTH - PORT_WIDTH;

    if (NB_PORTS < 2 || NB_PORTS > 16) begin : g_bad_ports
        $error("axis_addr_arb: NB_PORTS must be in 2..16");
    end
    if ((1 << PORT_WIDTH) < NB_PORTS) begin : g_bad_port_width
        $error("axis_addr_arb: PORT_WIDTH too small for NB_PORTS");
    end
    if (AXI_ID_WIDTH <= PORT_WIDTH) begin : g_bad_id_width
        $error("axis_addr_arb: AXI_ID_WIDTH must exceed PORT_WIDTH");
    end
    if ((1 << PTR_W) != ORDER_DEPTH) begin : g_bad_depth
        $error("axis_addr_arb: ORDER_DEPTH must be a power of two");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e                 state_q, state_d;
    logic [PORT_WIDTH-1:0]      last_grant_q;
    logic [AXI_ID_WIDTH-1:0]    m_aid_q;
    logic [AXI_ADDR_WIDTH-1:0]  m_aaddr_q;
    logic [AXI_LEN_WIDTH-1:0]   m_alen_q;

    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PORT_WIDTH-1:0]      fifo_port_mem [ORDER_DEPTH];
    logic [AXI_LEN_WIDTH-1:0]   fifo_len_mem  [ORDER_DEPTH];

    logic                       out_free;
    logic                       fifo_full;
    logic                       can_load;
    logic                       grant_found;
    logic [PORT_WIDTH-1:0]      grant_idx;
    logic                       grant_valid;
    logic                       fifo_push;
    logic                       fifo_pop;

    logic [LOW_ID_W-1:0]        sel_aid_low;
    logic [AXI_ADDR_WIDTH-1:0]  sel_aaddr;
    logic [AXI_LEN_WIDTH-1:0]   sel_alen;

    // ------------------------------------------------------------------
    // Output stage FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: combinational blocks assign a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant_valid) state_d = ST_FULL;
            ST_FULL: begin
                if (grant_valid)   state_d = ST_FULL;
                else if (m_aready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        m_avalid = 1'b0;
        out_free = 1'b1;
        case (state_q)
            ST_EMPTY: begin
                m_avalid = 1'b0;
                out_free = 1'b1;
            end
            ST_FULL: begin
                m_avalid = 1'b1;
                out_free = m_aready;
            end
            default: begin
                m_avalid = 1'b0;
                out_free = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin grant, searching upward from the port after last_grant
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == CNT_W'(ORDER_DEPTH));
    assign can_load  = out_free & ~fifo_full;

    always_comb begin : grant_search
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NB_PORTS; k++) begin
            cand = (int'(last_grant_q) + k) % NB_PORTS;
            if (!grant_found && s_avalid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PORT_WIDTH-1:0];
            end
        end
    end

    assign grant_valid = can_load & grant_found;

    // s_aready must read zero while reset is held, even before any clock edge.
    always_comb begin
        s_aready = '0;
        if (grant_valid && rst_n) begin
            s_aready = {{(NB_PORTS-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    assign sel_aid_low = s_aid[grant_idx*AXI_ID_WIDTH +: LOW_ID_W];
    assign sel_aaddr   = s_aaddr[grant_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign sel_alen    = s_alen[grant_idx*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];

    // ------------------------------------------------------------------
    // Output register and priority pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_aid_q      <= '0;
            m_aaddr_q    <= '0;
            m_alen_q     <= '0;
            last_grant_q <= PORT_WIDTH'(NB_PORTS - 1);
        end else if (grant_valid) begin
            m_aid_q      <= {grant_idx, sel_aid_low};
            m_aaddr_q    <= sel_aaddr;
            m_alen_q     <= sel_alen;
            last_grant_q <= grant_idx;
        end
    end

    assign m_aid   = m_aid_q;
    assign m_aaddr = m_aaddr_q;
    assign m_alen  = m_alen_q;

    // ------------------------------------------------------------------
    // Order FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign fifo_push  = grant_valid;
    assign wsel_valid = (count_q != '0);
    assign fifo_pop   = wsel_valid & wsel_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so
    // stale entries are never visible and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_port_mem[wr_ptr_q] <= grant_idx;
            fifo_len_mem[wr_ptr_q]  <= sel_alen;
        end
    end

    assign wsel_port = fifo_port_mem[rd_ptr_q];
    assign wsel_len  = fifo_len_mem[rd_ptr_q];

endmodule

// File: tb/tb_axis_addr_arb.sv
// Directed bench for axis_addr_arb: every accepted request is predicted into
// scoreboard queues and checked when the beat / order entry leaves the DUT.
module tb_axis_addr_arb;

    logic              clk;
    logic              rst_n;
    logic [3:0][7:0]   s_aid;
    logic [3:0][31:0]  s_aaddr;
    logic [3:0][7:0]   s_alen;
    logic [3:0]        s_avalid;
    logic [3:0]        s_aready;
    logic [7:0]        m_aid;
    logic [31:0]       m_aaddr;
    logic [7:0]        m_alen;
    logic              m_avalid;
    logic              m_aready;
    logic [1:0]        wsel_port;
    logic [7:0]        wsel_len;
    logic              wsel_valid;
    logic              wsel_ready;

    typedef struct packed {
        logic [7:0]  aid;
        logic [31:0] addr;
        logic [7:0]  len;
    } beat_t;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] len;
    } ord_t;

    beat_t mq[$];
    ord_t  fq[$];

    int vectors     = 0;
    int miscompares = 0;

    axis_addr_arb #(
        .NB_PORTS(4), .PORT_WIDTH(2), .AXI_ID_WIDTH(8), .AXI_LEN_WIDTH(8),
        .AXI_ADDR_WIDTH(32), .ORDER_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_aid(s_aid), .s_aaddr(s_aaddr), .s_alen(s_alen),
        .s_avalid(s_avalid), .s_aready(s_aready),
        .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen),
        .m_avalid(m_avalid), .m_aready(m_aready),
        .wsel_port(wsel_port), .wsel_len(wsel_len),
        .wsel_valid(wsel_valid), .wsel_ready(wsel_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples handshakes just before the edge, updates the scoreboard, then
    // advances to 1 time unit after the next rising edge.
    task automatic tick();
        beat_t b;
        ord_t  o;
        #1;
        if (rst_n) begin
            if (m_avalid && m_aready) begin
                chk("m_beat_queued", 64'(mq.size() > 0), 64'd1);
                if (mq.size() > 0) begin
                    b = mq.pop_front();
                    chk("m_aid", 64'(m_aid), 64'(b.aid));
                    chk("m_aaddr", 64'(m_aaddr), 64'(b.addr));
                    chk("m_alen", 64'(m_alen), 64'(b.len));
                end
            end
            if (wsel_valid && wsel_ready) begin
                chk("wsel_queued", 64'(fq.size() > 0), 64'd1);
                if (fq.size() > 0) begin
                    o = fq.pop_front();
                    chk("wsel_port", 64'(wsel_port), 64'(o.port));
                    chk("wsel_len", 64'(wsel_len), 64'(o.len));
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (s_avalid[p] && s_aready[p]) begin
                    b.aid  = {2'(p), s_aid[p][5:0]};
                    b.addr = s_aaddr[p];
                    b.len  = s_alen[p];
                    mq.push_back(b);
                    o.port = 2'(p);
                    o.len  = s_alen[p];
                    fq.push_back(o);
                end
            end
            chk("s_aready_onehot", 64'($countones(s_aready) <= 1), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mq.delete();
        fq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int   grants;
        logic [1:0] next_head;

        rst_n      = 1'b0;
        s_aid      = '0;
        s_aaddr    = '0;
        s_alen     = '0;
        s_avalid   = '0;
        m_aready   = 1'b0;
        wsel_ready = 1'b0;

        // Reset state, with requests present while reset is held
        repeat (2) @(posedge clk);
        #1;
        s_avalid = 4'hF;
        #1;
        chk("rst_s_aready", 64'(s_aready), 64'h0);
        chk("rst_m_avalid", 64'(m_avalid), 64'h0);
        chk("rst_m_aid", 64'(m_aid), 64'h0);
        chk("rst_m_aaddr", 64'(m_aaddr), 64'h0);
        chk("rst_wsel_valid", 64'(wsel_valid), 64'h0);
        s_avalid = '0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // Single-port flow on port 2
        s_aid[2]   = 8'h05;
        s_aaddr[2] = 32'h1000_0000;
        s_alen[2]  = 8'hFF;
        s_avalid   = 4'b0100;
        m_aready   = 1'b1;
        #1;
        chk("single_grant", 64'(s_aready), 64'h4);
        tick();
        s_avalid = '0;
        chk("single_m_avalid", 64'(m_avalid), 64'h1);
        chk("single_m_aid", 64'(m_aid), 64'h85);
        chk("single_m_aaddr", 64'(m_aaddr), 64'h1000_0000);
        chk("single_m_alen", 64'(m_alen), 64'hFF);
        chk("single_wsel_valid", 64'(wsel_valid), 64'h1);
        chk("single_wsel_port", 64'(wsel_port), 64'h2);
        chk("single_wsel_len", 64'(wsel_len), 64'hFF);
        tick();
        wsel_ready = 1'b1;
        tick();
        wsel_ready = 1'b0;
        chk("single_drained_m", 64'(m_avalid), 64'h0);
        chk("single_drained_w", 64'(wsel_valid), 64'h0);

        // Round-robin with all ports requesting after a fresh reset
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            s_aid[i]   = 8'h10 + 8'(i);
            s_aaddr[i] = 32'hA000_0000 + 32'(i * 16);
            s_alen[i]  = 8'(i + 1);
        end
        s_avalid   = 4'hF;
        m_aready   = 1'b1;
        wsel_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 64'(s_aready), 64'd1 << (k % 4));
            tick();
            chk("rr_m_avalid", 64'(m_avalid), 64'h1);
            chk("rr_wsel_head", 64'(wsel_port), 64'(k % 4));
        end

        // Backpressure: port 1 beat held for 5 cycles
        m_aready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("bp_s_aready", 64'(s_aready), 64'h0);
            chk("bp_m_avalid", 64'(m_avalid), 64'h1);
            chk("bp_m_aid", 64'(m_aid), 64'h51);
            chk("bp_m_aaddr", 64'(m_aaddr), 64'hA000_0010);
            chk("bp_m_alen", 64'(m_alen), 64'h2);
            tick();
        end
        m_aready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(s_aready), 64'h4);
        tick();
        chk("bp_release_addr", 64'(m_aaddr), 64'hA000_0020);
        s_avalid = '0;
        tick();
        tick();

        // FIFO full: no pops, continuous requests
        wsel_ready = 1'b0;
        s_avalid   = 4'hF;
        grants     = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_aready != '0) grants++;
            tick();
        end
        chk("full_grant_count", 64'(grants), 64'd16);
        #1;
        chk("full_blocked", 64'(s_aready), 64'h0);
        wsel_ready = 1'b1;
        #1;
        chk("full_pop_no_unblock", 64'(s_aready), 64'h0);
        tick();
        wsel_ready = 1'b0;
        #1;
        chk("full_one_more", 64'(s_aready), 64'h8);
        tick();
        #1;
        chk("full_again", 64'(s_aready), 64'h0);

        // Simultaneous push and pop with 3 entries held
        s_avalid   = '0;
        wsel_ready = 1'b1;
        repeat (13) tick();
        chk("pp_three_left", 64'(wsel_valid), 64'h1);
        s_avalid = 4'b0001;
        #1;
        chk("pp_grant", 64'(s_aready), 64'h1);
        next_head = fq[1].port;
        tick();
        s_avalid = '0;
        chk("pp_head_advanced", 64'(wsel_port), 64'(next_head));
        tick();
        tick();
        chk("pp_count_kept", 64'(wsel_valid), 64'h1);
        tick();
        chk("pp_empty", 64'(wsel_valid), 64'h0);
        wsel_ready = 1'b0;

        // Asynchronous reset between clock edges
        s_avalid = 4'hF;
        m_aready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_avalid", 64'(m_avalid), 64'h0);
        chk("arst_wsel_valid", 64'(wsel_valid), 64'h0);
        chk("arst_s_aready", 64'(s_aready), 64'h0);
        mq.delete();
        fq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst_first_grant", 64'(s_aready), 64'h1);
        tick();
        chk("arst_m_aid", 64'(m_aid), 64'h10);
        chk("arst_wsel_port", 64'(wsel_port), 64'h0);
        s_avalid   = '0;
        wsel_ready = 1'b1;
        tick();
        tick();
        chk("end_m_queue_empty", 64'(mq.size()), 64'd0);
        chk("end_w_queue_empty", 64'(fq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
